// File: rtl/npc_ram_pkg.sv
// Shared definitions for the NPC main-memory model and the MMIO decoder:
// store-size encodings, default window placement and the window hit test.
package npc_ram_pkg;

  // One-hot store size encodings carried on wdt_op.
  localparam logic [3:0] WDT_B = 4'b0001;
  localparam logic [3:0] WDT_H = 4'b0010;
  localparam logic [3:0] WDT_W = 4'b0100;
  localparam logic [3:0] WDT_D = 4'b1000;

  // Default RAM window: 64 KiB starting at the reset vector region.
  localparam logic [63:0] NPC_ADDR_BASE = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NPC_RAM_LEN   = 32'h0001_0000;

  // True when base <= addr < base + len. The upper bound is tested as an
  // offset so a window touching the top of the address space cannot
  // overflow the comparison.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [31:0] len);
    logic [63:0] off_v;
    off_v = addr - base;
    return (addr >= base) && (off_v < {32'h0000_0000, len});
  endfunction

endpackage

// File: rtl/npc_ram.sv
// Byte-addressable doubleword RAM for the single-cycle NPC core.
// Reads are combinational and return the aligned doubleword; stores merge
// 1/2/4/8 bytes into one doubleword on the falling edge of clk and never
// spill into the following doubleword.
module npc_ram
  import npc_ram_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE = NPC_ADDR_BASE,
  parameter logic [31:0] RAM_LEN   = NPC_RAM_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mem_raddr,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [3:0]  wdt_op,
  output logic [63:0] mem_rdata
);

  localparam int DEPTH = int'(RAM_LEN >> 3);
  localparam int IDX_W = $clog2(DEPTH);

  // Byte-lane mask for a store of size op at byte offset off. Lanes pushed
  // past bit 7 fall off the top, which is what stops misaligned stores from
  // wrapping. Anything other than a single size bit yields an empty mask.
  function automatic logic [7:0] byte_en(input logic [3:0] op,
                                         input logic [2:0] off);
    logic [15:0] m;
    case (op)
      WDT_B:   m = 16'h0001;
      WDT_H:   m = 16'h0003;
      WDT_W:   m = 16'h000F;
      WDT_D:   m = 16'h00FF;
      default: m = 16'h0000;
    endcase
    m = m << off;
    return m[7:0];
  endfunction

  logic [63:0] r_mem [DEPTH];

  logic [63:0]      w_roff;
  logic [63:0]      w_woff;
  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_widx;
  logic             w_rhit;
  logic             w_whit;
  logic             w_size_ok;
  logic             w_commit;
  logic [7:0]       w_be;
  logic [63:0]      w_wdata_sh;
  logic [63:0]      w_rdata;
  logic             w_unused;

  assign w_roff     = mem_raddr - ADDR_BASE;
  assign w_woff     = mem_waddr - ADDR_BASE;
  assign w_ridx     = w_roff[IDX_W+2:3];
  assign w_widx     = w_woff[IDX_W+2:3];
  assign w_rhit     = in_range(mem_raddr, ADDR_BASE, RAM_LEN);
  assign w_whit     = in_range(mem_waddr, ADDR_BASE, RAM_LEN);
  assign w_size_ok  = $onehot(wdt_op);
  assign w_be       = byte_en(wdt_op, mem_waddr[2:0]);
  assign w_wdata_sh = mem_wdata << {mem_waddr[2:0], 3'b000};
  assign w_commit   = mem_wen && !rst && w_whit && w_size_ok;

  // Offset bits above the window and the in-doubleword lane bits are not
  // part of the array index.
  assign w_unused = ^{w_roff[63:IDX_W+3], w_roff[2:0],
                      w_woff[63:IDX_W+3], w_woff[2:0]};

  // Store commit: byte-lane merge on the falling edge, with rst sampled there too.
  always_ff @(negedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 8; b++) begin
        if (w_be[b]) begin
          r_mem[w_widx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
        end
      end
    end
  end

  // Combinational read of the aligned doubleword; zero when idle or outside the window.
  always_comb begin
    w_rdata = 64'h0000_0000_0000_0000;
    if (mem_ren && w_rhit) begin
      w_rdata = r_mem[w_ridx];
    end else begin
      w_rdata = 64'h0000_0000_0000_0000;
    end
  end

  assign mem_rdata = w_rdata;

endmodule

// File: tb/tb_npc_ram.sv
// Self-checking bench for npc_ram: a byte-granular reference memory predicts
// every cycle's read data, the driver queues the prediction and a monitor
// compares it against mem_rdata after the falling (store) edge.
module tb_npc_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mem_raddr;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [3:0]  wdt_op;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  npc_ram dut (
    .clk       (clk),
    .rst       (rst),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .wdt_op    (wdt_op),
    .mem_rdata (mem_rdata)
  );

  // Reference memory: one entry per byte address.
  logic [7:0]  mdl [logic [63:0]];
  logic [63:0] exp_q [$];
  logic        mon_valid = 1'b0;
  int          n_checks  = 0;
  int          n_err     = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic mdl_in(input logic [63:0] a);
    return (a >= 64'h0000_0000_8000_0000) && (a < 64'h0000_0000_8001_0000);
  endfunction

  function automatic int size_of(input logic [3:0] op);
    case (op)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] mdl_read(input logic [63:0] a);
    logic [63:0] r;
    logic [63:0] dw;
    r  = 64'h0;
    dw = {a[63:3], 3'b000};
    if (mdl_in(a)) begin
      for (int i = 0; i < 8; i++) r[8*i +: 8] = mdl[dw + 64'(i)];
    end
    return r;
  endfunction

  // One cycle of stimulus: drive after the rising edge, update the model for
  // the store that commits at the coming falling edge, queue the expected
  // read data. Optionally check the pre-store value before the falling edge.
  task automatic cycle(input logic wen, input logic [63:0] waddr, input logic [63:0] wdata,
                       input logic [3:0] op, input logic ren, input logic [63:0] raddr,
                       input logic rstv, input logic use_c, input logic [63:0] c,
                       input logic chk_old);
    logic [63:0] old;
    logic [63:0] dw;
    int          n;
    @(posedge clk);
    #1;
    mem_wen = wen; mem_waddr = waddr; mem_wdata = wdata; wdt_op = op;
    mem_ren = ren; mem_raddr = raddr; rst = rstv;
    mon_valid = 1'b1;
    old = ren ? mdl_read(raddr) : 64'h0;
    n   = size_of(op);
    dw  = {waddr[63:3], 3'b000};
    if (wen && !rstv && mdl_in(waddr) && n > 0) begin
      for (int i = 0; i < n; i++) begin
        if (int'(waddr[2:0]) + i < 8) mdl[dw + 64'(waddr[2:0]) + 64'(i)] = wdata[8*i +: 8];
      end
    end
    exp_q.push_back(use_c ? c : (ren ? mdl_read(raddr) : 64'h0));
    if (chk_old) begin
      #2;
      check("pre_edge_old", mem_rdata, old);
    end
  endtask

  task automatic st(input logic [63:0] a, input logic [63:0] d, input logic [3:0] op);
    cycle(1'b1, a, d, op, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic rdc(input logic [63:0] a, input logic [63:0] c);
    cycle(1'b0, 64'h0, 64'h0, 4'b0000, 1'b1, a, 1'b0, 1'b1, c, 1'b0);
  endtask

  function automatic logic [63:0] pick_addr(input logic allow_wild);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 64'h8000_0000 + 64'($urandom_range(0, 255));
    else if (r == 7) return 64'h8000_FFF8 + 64'($urandom_range(0, 7));
    else if (r == 8) begin
      case ($urandom_range(0, 2))
        0:       return 64'h7FFF_FFF8 + 64'($urandom_range(0, 7));
        1:       return 64'h8001_0000 + 64'($urandom_range(0, 7));
        default: return 64'hA000_0000;
      endcase
    end
    else if (allow_wild) return {$urandom, $urandom};
    else return 64'hFFFF_FFFF_8000_0000;
  endfunction

  // Monitor: after each falling edge, compare read data with the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL scoreboard_underflow actual=empty required=entry at %0t", $time);
        end else begin
          check("rdata", mem_rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    rst = 1'b1; mem_wen = 1'b0; mem_ren = 1'b0; wdt_op = 4'b0000;
    mem_raddr = 64'h0; mem_waddr = 64'h0; mem_wdata = 64'h0;

    // Reset: idle reads return zero.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 64'h0, 64'h0, 4'b0000, 1'b0, 64'h8000_0000, 1'b1, 1'b0, 64'h0, 1'b0);

    // Initialise the doublewords the bench reads.
    for (int i = 0; i < 32; i++) st(64'h8000_0000 + 64'(8*i), 64'h0, 4'b1000);
    st(64'h8000_FFF8, 64'h0, 4'b1000);

    // Double store, then byte merge.
    st(64'h8000_0000, 64'h1122_3344_5566_7788, 4'b1000);
    rdc(64'h8000_0004, 64'h1122_3344_5566_7788);
    st(64'h8000_0003, 64'h0000_0000_0000_00AB, 4'b0001);
    rdc(64'h8000_0000, 64'h1122_3344_AB66_7788);

    // Half and word lanes.
    st(64'h8000_0016, 64'h0000_0000_0000_BEEF, 4'b0010);
    st(64'h8000_0010, 64'h0000_0000_DEAD_C0DE, 4'b0100);
    rdc(64'h8000_0010, 64'hBEEF_0000_DEAD_C0DE);

    // Out-of-range store and idle read.
    st(64'hA000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    rdc(64'hA000_0000, 64'h0);
    cycle(1'b0, 64'h0, 64'h0, 4'b0000, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 64'h0, 1'b0);

    // Reset and bad size block the store; the next clean store commits.
    cycle(1'b1, 64'h8000_0020, 64'h5A, 4'b0001, 1'b1, 64'h8000_0020, 1'b1, 1'b1, 64'h0, 1'b0);
    cycle(1'b1, 64'h8000_0020, 64'h5A, 4'b0011, 1'b1, 64'h8000_0020, 1'b0, 1'b1, 64'h0, 1'b0);
    cycle(1'b1, 64'h8000_0020, 64'h5A, 4'b0000, 1'b1, 64'h8000_0020, 1'b0, 1'b1, 64'h0, 1'b0);
    cycle(1'b1, 64'h8000_0020, 64'h5A, 4'b0001, 1'b1, 64'h8000_0020, 1'b0, 1'b1, 64'h5A, 1'b0);

    // Same-cycle read: old value before the falling edge, merged after it.
    cycle(1'b1, 64'h8000_0021, 64'h77, 4'b0001, 1'b1, 64'h8000_0020, 1'b0, 1'b1, 64'h775A, 1'b1);

    // Misaligned word: only lanes 6-7 written, next doubleword untouched.
    st(64'h8000_0006, 64'h0000_0000_CAFE_BABE, 4'b0100);
    rdc(64'h8000_0000, 64'hBABE_3344_AB66_7788);
    rdc(64'h8000_0008, 64'h0);

    // Window edges.
    st(64'h8000_FFFF, 64'hC3, 4'b0001);
    rdc(64'h8000_FFF8, 64'hC300_0000_0000_0000);
    st(64'h8001_0000, 64'h1, 4'b1000);
    rdc(64'h8001_0000, 64'h0);
    rdc(64'h7FFF_FFF8, 64'h0);

    // Randomized traffic against the reference memory.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 8) op = 4'(1 << $urandom_range(0, 3));
      else                          op = 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 3) != 0), pick_addr(1'b1), {$urandom, $urandom}, op,
            1'($urandom_range(0, 3) != 0), pick_addr(1'b0),
            1'($urandom_range(0, 15) == 0), 1'b0, 64'h0, 1'b0);
    end

    @(posedge clk);
    #1;
    mon_valid = 1'b0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
